key_scan_multi: RTL and testbench

//  Parametrised N-channel push-button front end: synchronises raw key inputs, debounces press and release,
//  and emits one-cycle press, release, long-press and auto-repeat strobes plus a debounced level per key.

---
 rtl/key_scan_pkg.sv | 26 ++
 rtl/key_debounce_ch.sv | 152 +++++++++++++++
 rtl/key_scan_multi.sv | 50 +++++
 tb/tb_key_scan_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared definitions for the multi-key scanner.
//   - 2-bit FSM state encoding for the per-channel debounce machine
//   - clog2 helper used to size the debounce and hold counters
package key_scan_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        PRESS_DB = ST_PRESS_DB,
        HELD     = ST_HELD,
        REL_DB   = ST_REL_DB
    } key_fsm_t;

    // Number of bits needed to hold values 0 .. value-1 (minimum 0).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel.
//   Two-flop synchroniser followed by a press/release debounce FSM with
//   long-press and auto-repeat timing.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   raw        asynchronous key pin
//   level      debounced level, 1 = pressed
//   press_stb  1-cycle strobe on accepted press
//   rel_stb    1-cycle strobe on accepted release
//   long_stb   1-cycle strobe after LONG_CYCLES held
//   rep_stb    1-cycle strobe every REPEAT_CYCLES after long_stb
module key_debounce_ch
    import key_scan_pkg::*;
#(
    parameter int ACTIVE_LEVEL  = 1,
    parameter int DEB_CYCLES    = 600,
    parameter int LONG_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press_stb,
    output logic rel_stb,
    output logic long_stb,
    output logic rep_stb
);

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DB_W     = clog2(DEB_CYCLES + 1);
    localparam int HOLD_W   = clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0]   DEB_LAST  = DB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic              ACT       = 1'(ACTIVE_LEVEL);

    logic              sync_p0;
    logic              sync_p1;
    logic              pressed;
    key_fsm_t          state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;

    // Synchroniser stage: resets to the idle pin level so no false press follows reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= ~ACT;
            sync_p1 <= ~ACT;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = (sync_p1 == ACT);

    // Debounce / hold-timing stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
            press_stb <= 1'b0;
            rel_stb   <= 1'b0;
            long_stb  <= 1'b0;
            rep_stb   <= 1'b0;
        end else begin
            press_stb <= 1'b0;
            rel_stb   <= 1'b0;
            long_stb  <= 1'b0;
            rep_stb   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        if (DEB_CYCLES == 1) begin
                            state     <= HELD;
                            press_stb <= 1'b1;
                            level     <= 1'b1;
                            hold_cnt  <= '0;
                            long_done <= 1'b0;
                            db_cnt    <= '0;
                        end else begin
                            state  <= PRESS_DB;
                            db_cnt <= DB_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DEB_LAST) begin
                        state     <= HELD;
                        press_stb <= 1'b1;
                        level     <= 1'b1;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        // Single-sample debounce releases immediately, mirroring the press path.
                        if (DEB_CYCLES == 1) begin
                            state   <= IDLE;
                            rel_stb <= 1'b1;
                            level   <= 1'b0;
                        end else begin
                            state  <= REL_DB;
                            db_cnt <= DB_W'(1);
                        end
                    end else if (!long_done && hold_cnt == LONG_LAST) begin
                        long_stb  <= 1'b1;
                        long_done <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (long_done && REPEAT_EN != 0 && hold_cnt == REP_LAST) begin
                        rep_stb  <= 1'b1;
                        hold_cnt <= '0;
                    end else if (!long_done || REPEAT_EN != 0) begin
                        // Without repeat the counter parks after key_long instead of wrapping.
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                REL_DB: begin
                    if (pressed) begin
                        // Release glitch: resume holding with timing state preserved.
                        state  <= HELD;
                        db_cnt <= '0;
                    end else if (db_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        rel_stb <= 1'b1;
                        level   <= 1'b0;
                        db_cnt  <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_scan_multi.sv
// key_scan_multi: KEY_NUM independent debounced push-button channels.
// Ports:
//   mclk         system clock
//   rst_n        synchronous active-low reset
//   key          raw asynchronous key pins
//   key_state    debounced level per key, 1 = pressed
//   key_press    1-cycle press strobes
//   key_release  1-cycle release strobes
//   key_long     1-cycle long-press strobes
//   key_rep      1-cycle auto-repeat strobes
module key_scan_multi
    import key_scan_pkg::*;
#(
    parameter int KEY_NUM       = 4,
    parameter int ACTIVE_LEVEL  = 1,
    parameter int DEB_CYCLES    = 600,
    parameter int LONG_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000,
    parameter int REPEAT_EN     = 1
) (
    input  logic               mclk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_rep
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LEVEL  (ACTIVE_LEVEL),
            .DEB_CYCLES    (DEB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN)
        ) u_ch (
            .clk       (mclk),
            .rst_n     (rst_n),
            .raw       (key[i]),
            .level     (key_state[i]),
            .press_stb (key_press[i]),
            .rel_stb   (key_release[i]),
            .long_stb  (key_long[i]),
            .rep_stb   (key_rep[i])
        );
    end

endmodule

// File: tb/tb_key_scan_multi.sv
// tb_key_scan_multi: bench for key_scan_multi.
//   dut_a: active-high keys, auto-repeat on.
//   dut_b: active-low keys, auto-repeat off.
//   Each clock the reference model is advanced from the pin values, and
//   all outputs of both instances are compared against it; directed
//   scenarios add explicit timing checks.
module tb_key_scan_multi;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_a, key_b;
    logic [3:0] st_a, pr_a, rl_a, lg_a, rp_a;
    logic [3:0] st_b, pr_b, rl_b, lg_b, rp_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: synchroniser copies, accepted level,
    // run of samples disagreeing with the level, held-sample count since press.
    bit         s0 [2][4];
    bit         s1 [2][4];
    bit         lvl [2][4];
    int         run [2][4];
    int         held [2][4];
    logic [3:0] e_st [2];
    logic [3:0] e_pr [2];
    logic [3:0] e_rl [2];
    logic [3:0] e_lg [2];
    logic [3:0] e_rp [2];

    always #5 clk = ~clk;

    key_scan_multi #(
        .KEY_NUM(4), .ACTIVE_LEVEL(1), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut_a (
        .mclk(clk), .rst_n(rst_n), .key(key_a), .key_state(st_a), .key_press(pr_a),
        .key_release(rl_a), .key_long(lg_a), .key_rep(rp_a)
    );

    key_scan_multi #(
        .KEY_NUM(4), .ACTIVE_LEVEL(0), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_b (
        .mclk(clk), .rst_n(rst_n), .key(key_b), .key_state(st_b), .key_press(pr_b),
        .key_release(rl_b), .key_long(lg_b), .key_rep(rp_b)
    );

    function automatic bit act(input int d);
        return (d == 0);
    endfunction

    function automatic bit rep_en(input int d);
        return (d == 0);
    endfunction

    task automatic model_edge();
        logic [3:0] raw;
        bit         p;
        for (int d = 0; d < 2; d++) begin
            raw = (d == 0) ? key_a : key_b;
            for (int c = 0; c < 4; c++) begin
                e_pr[d][c] = 1'b0;
                e_rl[d][c] = 1'b0;
                e_lg[d][c] = 1'b0;
                e_rp[d][c] = 1'b0;
                if (!rst_n) begin
                    s0[d][c]   = ~act(d);
                    s1[d][c]   = ~act(d);
                    lvl[d][c]  = 1'b0;
                    run[d][c]  = 0;
                    held[d][c] = 0;
                end else begin
                    p = (s1[d][c] == act(d));
                    if (p != lvl[d][c]) begin
                        run[d][c]++;
                        if (run[d][c] == DEB) begin
                            lvl[d][c]  = p;
                            run[d][c]  = 0;
                            held[d][c] = 0;
                            if (p) e_pr[d][c] = 1'b1;
                            else   e_rl[d][c] = 1'b1;
                        end
                    end else begin
                        // A sample that merely ends a release glitch does not advance hold time.
                        if (lvl[d][c] && run[d][c] == 0) begin
                            held[d][c]++;
                            if (held[d][c] == LONG)
                                e_lg[d][c] = 1'b1;
                            else if (rep_en(d) && held[d][c] > LONG && (held[d][c] - LONG) % REP == 0)
                                e_rp[d][c] = 1'b1;
                        end
                        run[d][c] = 0;
                    end
                    s1[d][c] = s0[d][c];
                    s0[d][c] = raw[c];
                end
                e_st[d][c] = lvl[d][c];
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("a_state",   st_a, e_st[0]);
        check("a_press",   pr_a, e_pr[0]);
        check("a_release", rl_a, e_rl[0]);
        check("a_long",    lg_a, e_lg[0]);
        check("a_rep",     rp_a, e_rp[0]);
        check("b_state",   st_b, e_st[1]);
        check("b_press",   pr_b, e_pr[1]);
        check("b_release", rl_b, e_rl[1]);
        check("b_long",    lg_b, e_lg[1]);
        check("b_rep",     rp_b, e_rp[1]);
    endtask

    initial begin
        bit   pat [5];
        int   rel_cnt, rep_cnt, press_cnt;
        bit   b_rep_seen;
        rst_n = 1'b0;
        key_a = 4'h0;
        key_b = 4'hF;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        b_rep_seen = 1'b0;

        // Reset, then idle: no spurious activity on either polarity.
        for (int i = 0; i < 3; i++) step();
        check("reset_state", st_a | pr_a | st_b | pr_b, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("idle_no_press", pr_a | pr_b, 4'h0);
        end

        // Clean press on key 0 (both polarities).
        key_a[0] = 1'b1;
        key_b[0] = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("t1_press_a", {3'b0, pr_a[0]}, (i == 5) ? 4'h1 : 4'h0);
            check("t1_state_a", {3'b0, st_a[0]}, (i >= 5) ? 4'h1 : 4'h0);
            check("t6_press_b", {3'b0, pr_b[0]}, (i == 5) ? 4'h1 : 4'h0);
        end
        key_a[0] = 1'b0;
        key_b[0] = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Bouncing press on key 1.
        press_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            key_a[1] = (i < 5) ? pat[i] : 1'b1;
            key_b[1] = ~key_a[1];
            step();
            if (pr_a[1]) press_cnt++;
            check("t2_press_at", {3'b0, pr_a[1]}, (i == 10) ? 4'h1 : 4'h0);
        end
        check("t2_press_count", 4'(press_cnt), 4'h1);
        key_a[1] = 1'b0;
        key_b[1] = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Long press and auto-repeat on key 2.
        key_a[2] = 1'b1;
        key_b[2] = 1'b0;
        for (int i = 0; i <= 65; i++) begin
            step();
            check("t3_long_a", {3'b0, lg_a[2]}, (i == 25) ? 4'h1 : 4'h0);
            check("t3_rep_a",  {3'b0, rp_a[2]}, (i > 25 && (i - 25) % REP == 0) ? 4'h1 : 4'h0);
            check("t3_long_b", {3'b0, lg_b[2]}, (i == 25) ? 4'h1 : 4'h0);
            b_rep_seen |= (rp_b != 4'h0);
        end

        // Two-cycle release glitch while repeating.
        rel_cnt = 0;
        rep_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            key_a[2] = (i == 1 || i == 2) ? 1'b0 : 1'b1;
            key_b[2] = ~key_a[2];
            step();
            if (rl_a[2]) rel_cnt++;
            if (rp_a[2]) rep_cnt++;
            b_rep_seen |= (rp_b != 4'h0);
        end
        check("t4_no_release", 4'(rel_cnt), 4'h0);
        check("t4_rep_continues", (rep_cnt > 0) ? 4'h1 : 4'h0, 4'h1);
        check("t4_norep_b", {3'b0, b_rep_seen}, 4'h0);

        key_a[2] = 1'b0;
        key_b[2] = 1'b1;
        rel_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rl_a[2]) rel_cnt++;
        end
        check("t3_one_release", 4'(rel_cnt), 4'h1);

        // All keys on one edge, then reset mid-hold and re-debounce.
        key_a = 4'hF;
        key_b = 4'h0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_all_press_a", pr_a, (i == 5) ? 4'hF : 4'h0);
            check("t5_all_press_b", pr_b, (i == 5) ? 4'hF : 4'h0);
        end
        rst_n = 1'b0;
        step();
        check("t5_rst_outputs_a", st_a | pr_a | rl_a | lg_a | rp_a, 4'h0);
        check("t5_rst_outputs_b", st_b | pr_b | rl_b | lg_b | rp_b, 4'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_repress_a", pr_a, (i == 5) ? 4'hF : 4'h0);
            check("t5_no_release", rl_a | rl_b, 4'h0);
        end
        key_a = 4'h0;
        key_b = 4'hF;
        for (int i = 0; i < 8; i++) step();

        // Randomised activity against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 24) == 0) key_a[c] = ~key_a[c];
                if ($urandom_range(0, 24) == 0) key_b[c] = ~key_b[c];
            end
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
